mux_rr_scheduler: RTL and testbench
===================================

# mux_rr_scheduler

Round-robin scheduler that shares the 8:1 data multiplexer among eight requesters. It owns the mux select lines: it picks one active requester, drives `sel` to that requester's index for a bounded time slot, and reports the grant one-hot. It sits directly in front of the 8:1 mux, with `sel` wired straight to the mux select input.

## Interface
- `SLOT_CYCLES`, default 4: maximum consecutive cycles one grant is held; legal range 1..256.
- `clk`  in  1: rising-edge clock.
- `rst`  in  1: reset, asynchronous and active-high.
- `req`  in  8: request per mux input; bit i requests data input i.
- `gnt`  out  8: one-hot grant; at most one bit set.
- `sel`  out  3: mux select; equals the index of the set `gnt` bit while `valid`=1.
- `valid`  out  1: a grant is active, so mux output is meaningful.
- `slot_last`  out  1: current cycle is the final cycle of the active grant.

## Operation
- States:
  - IDLE: no grant.
  - BUSY: a grant is active.
- Registers:
  - `ptr` (3 b): highest-priority index for the next arbitration.
  - `slot_cnt` (8 b): cycles elapsed in the current slot.
- Arbitration: search `req` circularly from `ptr` upward (`ptr`, `ptr`+1, …, wrap 7→0). The first set bit wins.
- Winner update: on every grant, `ptr` ← winner+1 mod 8. Index 7 wraps `ptr` to 0.
- IDLE → BUSY: at the edge where any `req` bit is 1.
  - Load `gnt`/`sel` from the winner, set `valid`=1, `slot_cnt`=0.
- Slot end: a BUSY grant ends at the edge where either condition holds:
  - (a) `slot_cnt` = `SLOT_CYCLES`−1, or
  - (b) the granted requester's `req` bit is 0.
- At a slot-end edge:
  - Arbitrate among the current `req`. If any bit is set, regrant with no idle cycle (BUSY→BUSY, `slot_cnt`=0).
  - Otherwise go to IDLE and clear `gnt`, `valid`, `slot_last`. `sel` holds its last value.
- Sole requester: if it is the only one still requesting at slot end, it is regranted. Round-robin fairness never inserts a bubble.
- `slot_last` = BUSY and (`slot_cnt` = `SLOT_CYCLES`−1). Combinational from state. It does not reflect the dropped-`req` case.
- `SLOT_CYCLES`=1 gives a fresh arbitration every cycle, with `slot_last` constantly 1 while BUSY.
- Requests changing mid-slot have no effect until the slot-end edge; there is no preemption.

## Timing
- Reset values, applied immediately on `rst` and held while it is high:
  - state=IDLE, `gnt`=0, `sel`=0, `valid`=0, `slot_last`=0, `ptr`=0, `slot_cnt`=0.
- Reset mid-slot: the grant drops asynchronously; the first arbitration after release starts from index 0.
- Latency: `req` sampled high at edge k gives `gnt`/`sel`/`valid` valid after edge k. That is one cycle from the request being visible to the grant.
- Slot length: with `req` held, a grant lasts exactly `SLOT_CYCLES` cycles.
- Early release: dropping `req` at cycle c of a slot ends the grant after the next edge.
- Handoff: back-to-back grants switch `sel` on the same edge that ends the previous slot. The mux input changes cleanly at a clock boundary.
- Requesters must keep `req` high until `gnt` is seen; `req` is not latched.

## Structure
- Shared package `mux_sched_pkg`:
  - `N_REQ`=8, `SEL_W`=3.
  - State encoding constants `ST_IDLE`, `ST_BUSY`.
- Sub-module `rr_prio_enc`: combinational, `req[7:0]` + `ptr[2:0]` → `found`, `idx[2:0]`.
  - Implemented by rotate-right by `ptr`, fixed LSB-first priority, then add `ptr` back mod 8.
- Top level: FSM, `ptr`, `slot_cnt`, output registers, and one `rr_prio_enc` instance.
- The scheduler does not instantiate the mux; it is instantiated alongside it.

## Test plan
- Reset: hold `rst`=1 with `req`=8'hFF.
  - Require `gnt`=0, `sel`=0, `valid`=0 throughout.
  - After release, first grant is `sel`=0 on the next edge.
- Full load: `SLOT_CYCLES`=4 with `req`=8'hFF held.
  - Require `sel` sequence 0,1,…,7,0, each held 4 cycles.
  - No bubble; `slot_last` high on every 4th cycle.
- Early drop: `req`=8'b0000_0101.
  - `sel`=0 granted; drop `req[0]` after 2 cycles.
  - Require `sel`=2 on the following edge; `valid` stays 1.
- Wrap and skip: `ptr`=6 after granting 5, `req`=8'b0000_1001.
  - Require next grant `sel`=0, then `sel`=3.
- Sole requester: `req`=8'h10 held for 10 cycles, `SLOT_CYCLES`=4.
  - Require `sel`=4 and `valid`=1 continuously.
  - `slot_last` pulses at cycles 4 and 8.
  - Drop `req` → IDLE and `valid`=0 after one edge.
- Async reset mid-slot: assert `rst` between clock edges during a BUSY grant.
  - Require `gnt`, `valid`, `slot_last` to go 0 before the next edge.
  - After release, arbitration restarts from index 0.

Source files
------------

// File: rtl/mux_sched_pkg.sv
// Shared constants and state encoding for the round-robin mux scheduler.
package mux_sched_pkg;
    localparam int N_REQ = 8;
    localparam int SEL_W = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;
endpackage

// File: rtl/mux_rr_scheduler_if.sv
// Request/grant bundle between the requesters (master) and the scheduler (slave).
interface mux_rr_scheduler_if;
    import mux_sched_pkg::*;

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] gnt;
    logic [SEL_W-1:0] sel;
    logic             valid;
    logic             slot_last;

    modport master (output req, input gnt, input sel, input valid, input slot_last);
    modport slave  (input req, output gnt, output sel, output valid, output slot_last);
endinterface

// File: rtl/rr_prio_enc.sv
// Circular priority encoder: first set request at or above ptr, wrapping 7 -> 0.
module rr_prio_enc
    import mux_sched_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             found,
    output logic [SEL_W-1:0] idx
);
    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    logic [SEL_W-1:0]   pos;

    always_comb begin
        dbl   = {req, req};
        rot   = N_REQ'(dbl >> ptr);
        found = |rot;
        pos   = '0;
        // Descending scan so the lowest set bit of the rotated vector wins.
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) pos = SEL_W'(i);
        end
        idx = pos + ptr;
    end
endmodule

// File: rtl/mux_rr_scheduler.sv
// Round-robin owner of the 8:1 mux select: grants one requester for up to SLOT_CYCLES cycles.
module mux_rr_scheduler
    import mux_sched_pkg::*;
#(
    parameter int SLOT_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    mux_rr_scheduler_if.slave bus
);
    localparam logic [7:0] CNT_LAST = 8'(SLOT_CYCLES - 1);

    state_t           state, state_nxt;
    logic [SEL_W-1:0] ptr, ptr_nxt;
    logic [SEL_W-1:0] sel_q, sel_nxt;
    logic [7:0]       slot_cnt, cnt_nxt;
    logic             found;
    logic [SEL_W-1:0] win;
    logic             busy;
    logic             at_last;
    logic             slot_end;

    rr_prio_enc u_enc (
        .req   (bus.req),
        .ptr   (ptr),
        .found (found),
        .idx   (win)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            ptr      <= '0;
            sel_q    <= '0;
            slot_cnt <= '0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            sel_q    <= sel_nxt;
            slot_cnt <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        sel_nxt   = sel_q;
        cnt_nxt   = slot_cnt;
        busy      = (state == ST_BUSY);
        at_last   = busy && (slot_cnt == CNT_LAST);
        // A dropped request ends the slot early but is not flagged on slot_last.
        slot_end  = at_last || !bus.req[sel_q];

        case (state)
            ST_IDLE: begin
                if (found) begin
                    state_nxt = ST_BUSY;
                    sel_nxt   = win;
                    ptr_nxt   = win + 3'd1;
                    cnt_nxt   = '0;
                end
            end
            ST_BUSY: begin
                if (slot_end) begin
                    if (found) begin
                        sel_nxt = win;
                        ptr_nxt = win + 3'd1;
                        cnt_nxt = '0;
                    end else begin
                        state_nxt = ST_IDLE;
                        cnt_nxt   = '0;
                    end
                end else begin
                    cnt_nxt = slot_cnt + 8'd1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        bus.valid     = busy;
        bus.slot_last = at_last;
        bus.sel       = sel_q;
        bus.gnt       = busy ? (N_REQ'(1) << sel_q) : '0;
    end
endmodule

// File: tb/tb_mux_rr_scheduler.sv
// Randomized and directed bench for mux_rr_scheduler with a behavioural round-robin model.
module tb_mux_rr_scheduler;
    import mux_sched_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    mux_rr_scheduler_if if0 ();
    mux_rr_scheduler_if if1 ();

    mux_rr_scheduler #(.SLOT_CYCLES(4)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    mux_rr_scheduler #(.SLOT_CYCLES(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic set_req(input logic [7:0] v);
        if0.req = v;
        if1.req = v;
    endtask

    // Behavioural model: owner index (-1 = none), cycles used, next-priority pointer.
    int m_own [2];
    int m_cnt [2];
    int m_ptr [2];
    int m_sel [2];
    int m_slot[2] = '{4, 1};

    function automatic int arb(input int p, input logic [7:0] r);
        for (int k = 0; k < 8; k++)
            if (r[(p + k) % 8]) return (p + k) % 8;
        return -1;
    endfunction

    always @(posedge clk or posedge rst) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_own[d] = -1; m_cnt[d] = 0; m_ptr[d] = 0; m_sel[d] = 0;
            end else begin
                int  w;
                bit  ended;
                ended = (m_own[d] < 0) || (m_cnt[d] == m_slot[d] - 1) || !if0.req[m_own[d]];
                if (ended) begin
                    w = arb(m_ptr[d], if0.req);
                    if (w >= 0) begin
                        m_own[d] = w; m_sel[d] = w; m_cnt[d] = 0; m_ptr[d] = (w + 1) % 8;
                    end else begin
                        m_own[d] = -1; m_cnt[d] = 0;
                    end
                end else begin
                    m_cnt[d]++;
                end
            end
        end
    end

    // Every cycle, compare both instances against the model.
    always @(negedge clk) begin
        int eg;
        eg = (m_own[0] >= 0) ? (1 << m_own[0]) : 0;
        chk("dut0 gnt", int'(if0.gnt), eg);
        chk("dut0 sel", int'(if0.sel), m_sel[0]);
        chk("dut0 valid", int'(if0.valid), int'(m_own[0] >= 0));
        chk("dut0 slot_last", int'(if0.slot_last), int'(m_own[0] >= 0 && m_cnt[0] == 3));
        eg = (m_own[1] >= 0) ? (1 << m_own[1]) : 0;
        chk("dut1 gnt", int'(if1.gnt), eg);
        chk("dut1 sel", int'(if1.sel), m_sel[1]);
        chk("dut1 valid", int'(if1.valid), int'(m_own[1] >= 0));
        chk("dut1 slot_last", int'(if1.slot_last), int'(m_own[1] >= 0));
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        set_req(8'h00);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        set_req(8'hFF);

        // Reset held with all requests high.
        repeat (3) begin
            @(negedge clk);
            chk("reset gnt", int'(if0.gnt), 0);
            chk("reset sel", int'(if0.sel), 0);
            chk("reset valid", int'(if0.valid), 0);
        end
        rst = 1'b0;

        // Full load: 0..7,0 each for 4 cycles; SLOT_CYCLES=1 instance rotates every cycle.
        for (int n = 0; n < 36; n++) begin
            @(negedge clk);
            chk("full sel", int'(if0.sel), (n / 4) % 8);
            chk("full valid", int'(if0.valid), 1);
            chk("full slot_last", int'(if0.slot_last), int'(n % 4 == 3));
            chk("full1 sel", int'(if1.sel), n % 8);
            chk("full1 slot_last", int'(if1.slot_last), 1);
        end

        // Early drop of requester 0 hands off to 2 without a bubble.
        do_reset();
        set_req(8'b0000_0101);
        @(negedge clk); chk("drop sel c1", int'(if0.sel), 0);
        @(negedge clk); chk("drop sel c2", int'(if0.sel), 0);
        set_req(8'b0000_0100);
        @(negedge clk);
        chk("drop sel next", int'(if0.sel), 2);
        chk("drop valid", int'(if0.valid), 1);

        // Wrap and skip: after granting 5, pointer 6 wraps to 0, then 3.
        do_reset();
        set_req(8'h20);
        @(negedge clk); chk("wrap sel5", int'(if0.sel), 5);
        set_req(8'b0000_1001);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); chk("wrap sel0", int'(if0.sel), 0);
        end
        @(negedge clk); chk("wrap sel3", int'(if0.sel), 3);

        // Sole requester keeps the mux with slot_last at cycles 4 and 8.
        do_reset();
        set_req(8'h10);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            chk("sole sel", int'(if0.sel), 4);
            chk("sole valid", int'(if0.valid), 1);
            chk("sole slot_last", int'(if0.slot_last), int'(c == 4 || c == 8));
        end
        set_req(8'h00);
        @(negedge clk);
        chk("sole idle valid", int'(if0.valid), 0);
        chk("sole idle gnt", int'(if0.gnt), 0);
        chk("sole idle sel", int'(if0.sel), 4);

        // Asynchronous reset in the middle of a slot.
        set_req(8'hFF);
        repeat (6) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("areset gnt", int'(if0.gnt), 0);
        chk("areset valid", int'(if0.valid), 0);
        chk("areset slot_last", int'(if0.slot_last), 0);
        chk("areset sel", int'(if0.sel), 0);
        chk("areset1 valid", int'(if1.valid), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("areset regrant sel", int'(if0.sel), 0);
        chk("areset regrant valid", int'(if0.valid), 1);

        // Random traffic, with occasional resets, checked by the model every cycle.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) set_req(8'($urandom));
            if ($urandom_range(0, 4) == 0) set_req(8'($urandom) & 8'($urandom));
            if ($urandom_range(0, 299) == 0) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
        end

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
